// File: rtl/traffic_pkg.sv
// Encodings shared between the intersection light controller and its input stages.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED          = 2'b00,
    YELLOW       = 2'b01,
    GREEN        = 2'b10,
    BLINKING_RED = 2'b11
  } light_t;

  typedef enum logic [2:0] {
    ST_A_GREEN   = 3'd0,
    ST_A_YELLOW  = 3'd1,
    ST_ALL_RED_A = 3'd2,
    ST_B_GREEN   = 3'd3,
    ST_B_YELLOW  = 3'd4,
    ST_ALL_RED_B = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam int NUM_SENSORS = 4;
  localparam int SEN_CAR_A   = 0;
  localparam int SEN_CAR_B   = 1;
  localparam int SEN_BTN_A   = 2;
  localparam int SEN_BTN_B   = 3;

  function automatic logic is_green(input logic [1:0] light);
    return light == GREEN;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a counting debouncer; emits the debounced
// level and a one-cycle pulse on each debounced rising edge.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             stable_next;
  logic             rise_reg;
  logic             rise_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    stable_next = stable_reg;
    rise_next   = 1'b0;
    cnt_next    = '0;
    // Any sample agreeing with the stable value restarts the stability window.
    if (sync2_reg != stable_reg) begin
      if (cnt_reg == CNT_LAST) begin
        stable_next = sync2_reg;
        rise_next   = sync2_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      rise_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg  <= raw;
      sync2_reg  <= sync1_reg;
      stable_reg <= stable_next;
      rise_reg   <= rise_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign level = stable_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/traffic_request_conditioner.sv
// Conditions loop detectors and push-buttons into latched per-road service
// requests and pedestrian wait lamps, cleared when the served road shows green.
module traffic_request_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CAR_A_RAW,
  input  logic       CAR_B_RAW,
  input  logic       BTN_A_RAW,
  input  logic       BTN_B_RAW,
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic       SA,
  output logic       SB,
  output logic       WAIT_A,
  output logic       WAIT_B
);

  logic [NUM_SENSORS-1:0] raw_vec;
  logic [NUM_SENSORS-1:0] level_vec;
  logic [NUM_SENSORS-1:0] rise_vec;

  assign raw_vec[SEN_CAR_A] = CAR_A_RAW;
  assign raw_vec[SEN_CAR_B] = CAR_B_RAW;
  assign raw_vec[SEN_BTN_A] = BTN_A_RAW;
  assign raw_vec[SEN_BTN_B] = BTN_B_RAW;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_sensor
      sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_debounce (
        .CLK  (CLK),
        .RST  (RST),
        .raw  (raw_vec[gi]),
        .level(level_vec[gi]),
        .rise (rise_vec[gi])
      );
    end
  endgenerate

  logic a_green;
  logic b_green;
  logic sa_reg, sa_next;
  logic sb_reg, sb_next;
  logic wait_a_reg, wait_a_next;
  logic wait_b_reg, wait_b_next;

  assign a_green = is_green(A);
  assign b_green = is_green(B);

  // Crossing A walks on road-B green (and vice versa), hence the cross-wiring
  // of buttons to requests. Clear dominates: a set during green is dropped.
  always_comb begin
    sa_next     = sa_reg | level_vec[SEN_CAR_A] | rise_vec[SEN_BTN_B];
    sb_next     = sb_reg | level_vec[SEN_CAR_B] | rise_vec[SEN_BTN_A];
    wait_a_next = wait_a_reg | rise_vec[SEN_BTN_A];
    wait_b_next = wait_b_reg | rise_vec[SEN_BTN_B];
    if (a_green) begin
      sa_next     = 1'b0;
      wait_b_next = 1'b0;
    end
    if (b_green) begin
      sb_next     = 1'b0;
      wait_a_next = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sa_reg     <= 1'b0;
      sb_reg     <= 1'b0;
      wait_a_reg <= 1'b0;
      wait_b_reg <= 1'b0;
    end else begin
      sa_reg     <= sa_next;
      sb_reg     <= sb_next;
      wait_a_reg <= wait_a_next;
      wait_b_reg <= wait_b_next;
    end
  end

  assign SA     = sa_reg;
  assign SB     = sb_reg;
  assign WAIT_A = wait_a_reg;
  assign WAIT_B = wait_b_reg;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Directed bench: stimulus queues hand-computed {SA,SB,WAIT_A,WAIT_B} per edge,
// a monitor pops and compares after each rising edge or async-reset probe.
module tb_traffic_request_conditioner;
  import traffic_pkg::*;

  logic       CLK;
  logic       RST;
  logic       car_a_raw, car_b_raw, btn_a_raw, btn_b_raw;
  logic [1:0] A, B;
  logic       SA, SB, WAIT_A, WAIT_B;

  typedef struct {
    logic [3:0] exp;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event chk_now;

  traffic_request_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CAR_A_RAW(car_a_raw),
    .CAR_B_RAW(car_b_raw),
    .BTN_A_RAW(btn_a_raw),
    .BTN_B_RAW(btn_b_raw),
    .A        (A),
    .B        (B),
    .SA       (SA),
    .SB       (SB),
    .WAIT_A   (WAIT_A),
    .WAIT_B   (WAIT_B)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // Monitor: one popped expectation per rising edge (or per async probe).
  initial begin
    exp_t       e;
    logic [3:0] got;
    forever begin
      @(posedge CLK or chk_now);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {SA, SB, WAIT_A, WAIT_B};
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got SA/SB/WA/WB=%b expected %b at %0t", e.tag, got, e.exp, $time);
        end else begin
          $display("ok   %s: SA/SB/WA/WB=%b at %0t", e.tag, got, $time);
        end
      end
    end
  end

  task automatic push(input logic [3:0] exp, input string tag);
    exp_t e;
    e.exp = exp;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic run(input int n, input logic [3:0] exp, input string tag);
    for (int i = 0; i < n; i++) begin
      push(exp, tag);
      @(negedge CLK);
    end
  endtask

  task automatic set_raw(input logic ca, input logic cb, input logic ba, input logic bb);
    car_a_raw = ca;
    car_b_raw = cb;
    btn_a_raw = ba;
    btn_b_raw = bb;
  endtask

  initial begin
    RST = 1'b1;
    set_raw(1'b0, 1'b0, 1'b0, 1'b0);
    A = RED;
    B = RED;
    #1 RST = 1'b0;
    set_raw(1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge CLK);

    // Reset with every input high, then a fresh debounce after release.
    run(3, 4'b0000, "reset_hold");
    RST = 1'b1;
    run(6, 4'b0000, "post_reset_debounce");
    run(1, 4'b1111, "post_reset_edge6");

    set_raw(1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    run(2, 4'b0000, "clean_reset");
    RST = 1'b1;
    run(8, 4'b0000, "idle");

    // Glitch filtering on CAR_B.
    car_b_raw = 1'b1;
    run(3, 4'b0000, "glitch3_pulse");
    car_b_raw = 1'b0;
    run(10, 4'b0000, "glitch3_after");
    car_b_raw = 1'b1;
    run(6, 4'b0000, "pulse6_debounce");
    car_b_raw = 1'b0;
    run(1, 4'b0100, "pulse6_set");
    run(8, 4'b0100, "pulse6_hold");

    // Serve and re-assert through the level path.
    car_b_raw = 1'b1;
    run(8, 4'b0100, "car_b_present");
    B = GREEN;
    run(1, 4'b0000, "serve_b");
    B = RED;
    run(1, 4'b0100, "reassert_b");
    car_b_raw = 1'b0;
    run(8, 4'b0100, "car_b_leave");
    B = GREEN;
    run(1, 4'b0000, "serve_b_final");
    B = RED;
    run(3, 4'b0000, "b_idle");

    // Pedestrian A: short press.
    btn_a_raw = 1'b1;
    run(6, 4'b0000, "ped_a_debounce");
    run(4, 4'b0110, "ped_a_set");
    btn_a_raw = 1'b0;
    run(8, 4'b0110, "ped_a_release");
    B = GREEN;
    run(1, 4'b0000, "ped_a_serve");
    B = RED;
    run(3, 4'b0000, "ped_a_idle");

    // Pedestrian A: 40-cycle hold served mid-press, then re-press.
    btn_a_raw = 1'b1;
    run(6, 4'b0000, "hold_debounce");
    run(9, 4'b0110, "hold_set");
    B = GREEN;
    run(1, 4'b0000, "hold_serve");
    B = RED;
    run(24, 4'b0000, "hold_no_reset");
    btn_a_raw = 1'b0;
    run(8, 4'b0000, "hold_release");
    btn_a_raw = 1'b1;
    run(6, 4'b0000, "repress_debounce");
    run(2, 4'b0110, "repress_set");
    btn_a_raw = 1'b0;
    run(8, 4'b0110, "repress_release");
    B = GREEN;
    run(1, 4'b0000, "repress_serve");
    B = RED;
    run(2, 4'b0000, "repress_idle");

    // Mapping: BTN_B + CAR_A against road A green, then red.
    A = GREEN;
    car_a_raw = 1'b1;
    btn_b_raw = 1'b1;
    run(10, 4'b0000, "map_a_green");
    car_a_raw = 1'b0;
    btn_b_raw = 1'b0;
    run(8, 4'b0000, "map_release");
    A = RED;
    run(2, 4'b0000, "map_red_idle");
    car_a_raw = 1'b1;
    btn_b_raw = 1'b1;
    run(6, 4'b0000, "map_debounce");
    run(3, 4'b1001, "map_set");

    // Async reset mid-debounce of CAR_B while SA is up.
    car_b_raw = 1'b1;
    run(2, 4'b1001, "async_pre");
    push(4'b1001, "async_pre_edge");
    @(posedge CLK);
    #3 RST = 1'b0;
    #1 push(4'b0000, "async_drop");
    ->chk_now;
    #3 RST = 1'b1;
    @(negedge CLK);
    run(6, 4'b0000, "async_redebounce");
    run(1, 4'b1101, "async_return");

    // YELLOW and 11 never clear; GREEN on A clears SA and WAIT_B only.
    A = YELLOW;
    run(2, 4'b1101, "a_yellow_no_clear");
    A = BLINKING_RED;
    run(2, 4'b1101, "a_blink_no_clear");
    A = GREEN;
    run(1, 4'b0100, "a_green_clear");

    @(posedge CLK);
    #3;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
